// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared types and helpers for the PS/2 keyboard controller.
//   dec_state_e       : scan-code decode states (BASE, EXT, BREAK, EXT_BREAK)
//   frame_state_e     : serial frame receiver states (IDLE, DATA, PARITY, STOP)
//   PS2_EXT/BRK       : extended-prefix and break-prefix scan codes
//   PS2_LSHIFT/RSHIFT : shift key make codes
//   ps2_set2_to_ascii : set-2 make code -> ASCII (0x00 for unmapped codes)
// Build option: PS2_SHIFT_EN enables shift-key tracking (lowercase letters
// unless a shift is held, shifted digit row and '?').
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {BASE, EXT, BREAK, EXT_BREAK} dec_state_e;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

`ifdef PS2_SHIFT_EN
  localparam bit PS2_SHIFT_FEATURE = 1'b1;
`else
  localparam bit PS2_SHIFT_FEATURE = 1'b0;
`endif

  // Without the shift feature letters are always uppercase and symbols are
  // never shifted, whatever the caller passes in.
  function automatic logic [7:0] ps2_set2_to_ascii(input logic [7:0] code,
                                                   input logic       shift);
    logic [7:0] ch;
    logic       caps;
    logic       sym;
    caps = shift || !PS2_SHIFT_FEATURE;
    sym  = shift && PS2_SHIFT_FEATURE;
    case (code)
      8'h1C: ch = "A";  8'h32: ch = "B";  8'h21: ch = "C";  8'h23: ch = "D";
      8'h24: ch = "E";  8'h2B: ch = "F";  8'h34: ch = "G";  8'h33: ch = "H";
      8'h43: ch = "I";  8'h3B: ch = "J";  8'h42: ch = "K";  8'h4B: ch = "L";
      8'h3A: ch = "M";  8'h31: ch = "N";  8'h44: ch = "O";  8'h4D: ch = "P";
      8'h15: ch = "Q";  8'h2D: ch = "R";  8'h1B: ch = "S";  8'h2C: ch = "T";
      8'h3C: ch = "U";  8'h2A: ch = "V";  8'h1D: ch = "W";  8'h22: ch = "X";
      8'h35: ch = "Y";  8'h1A: ch = "Z";
      8'h45: ch = sym ? ")" : "0";
      8'h16: ch = sym ? "!" : "1";
      8'h1E: ch = sym ? "@" : "2";
      8'h26: ch = sym ? "#" : "3";
      8'h25: ch = sym ? "$" : "4";
      8'h2E: ch = sym ? "%" : "5";
      8'h36: ch = sym ? "^" : "6";
      8'h3D: ch = sym ? "&" : "7";
      8'h3E: ch = sym ? "*" : "8";
      8'h46: ch = sym ? "(" : "9";
      8'h29: ch = " ";
      8'h41: ch = ",";
      8'h49: ch = ".";
      8'h4A: ch = sym ? "?" : "/";
      8'h5A: ch = 8'h0D;
      8'h66: ch = 8'h08;
      default: ch = 8'h00;
    endcase
    // Table holds uppercase; fold to lowercase only inside the letter range.
    if (!caps && (ch >= "A") && (ch <= "Z")) begin
      ch = ch + 8'h20;
    end
    return ch;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ---------------------------------------------------------------------------
// ps2_rx_frame
// Synchronises PS2_CLK/PS2_DAT, detects falling keyboard-clock edges and
// assembles 11-bit frames (start, 8 data LSB first, odd parity, stop).
//   clk_i, rst_i   : system clock, async active-high reset
//   ps2_clk_i/dat_i: raw keyboard lines
//   rx_byte_o      : last received byte (valid while rx_vld_o is high)
//   rx_vld_o       : one-cycle pulse for each good frame
//   frame_err_o    : one-cycle pulse on start/parity/stop error or timeout
//   busy_o         : frame FSM not IDLE
// ---------------------------------------------------------------------------
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_vld_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;

  frame_state_e state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shreg_q, shreg_d;
  logic         par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic         rx_vld_q, rx_vld_d;
  logic         err_q, err_d;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q && !clk_s;

  // Idle-high lines: reset the synchronisers to 1 so reset release never
  // looks like a falling edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev_q <= clk_s;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    rx_vld_d  = 1'b0;
    err_d     = 1'b0;
    tmo_d     = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);
    // A falling edge in the same cycle as expiry keeps the frame alive.
    if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shreg_d   = {dat_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          if ((^shreg_q ^ par_q) && dat_s) rx_vld_d = 1'b1;
          else                             err_d    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'h00;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      rx_vld_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      rx_vld_q  <= rx_vld_d;
      err_q     <= err_d;
    end
  end

  assign rx_byte_o   = shreg_q;
  assign rx_vld_o    = rx_vld_q;
  assign frame_err_o = err_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_kbd_ctrl
// PS/2 keyboard front end: frame receiver, set-2 decode to ASCII, character
// FIFO and sticky error flags.
//   CLK, RST            : system clock, async active-high reset
//   PS2_CLK, PS2_DAT    : keyboard lines (asynchronous)
//   KEY_ASCII/KEY_VALID : FIFO head (0x00 when empty) / FIFO not empty
//   KEY_READY           : consumer accept
//   FIFO_COUNT          : entries held
//   ERR                 : [0] frame error, [1] FIFO overflow (sticky)
//   CLR_ERR             : clears ERR (a same-cycle new error still sets)
//   BUSY                : frame receiver mid-frame
// Handshake: a character transfers on every cycle where KEY_VALID and
// KEY_READY are both high; KEY_ASCII is stable while KEY_VALID is high and
// not accepted. KEY_READY with KEY_VALID low has no effect.
// Build option: PS2_SHIFT_EN adds left/right shift tracking.
// ---------------------------------------------------------------------------
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            PS2_CLK,
  input  logic                            PS2_DAT,
  output logic [7:0]                      KEY_ASCII,
  output logic                            KEY_VALID,
  input  logic                            KEY_READY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] FIFO_COUNT,
  output logic [1:0]                      ERR,
  input  logic                            CLR_ERR,
  output logic                            BUSY
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       frame_err;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk_i      (CLK),
    .rst_i      (RST),
    .ps2_clk_i  (PS2_CLK),
    .ps2_dat_i  (PS2_DAT),
    .rx_byte_o  (rx_byte),
    .rx_vld_o   (rx_vld),
    .frame_err_o(frame_err),
    .busy_o     (BUSY)
  );

  // ---------------- decode FSM ----------------
  dec_state_e dec_q, dec_d;
  logic       push_q, push_d;
  logic [7:0] push_char_q, push_char_d;
  logic [7:0] lookup;
  logic       shift_held;

`ifdef PS2_SHIFT_EN
  logic lshift_q, lshift_d, rshift_q, rshift_d;
  assign shift_held = lshift_q || rshift_q;
`else
  assign shift_held = 1'b0;
`endif

  always_comb begin
    dec_d       = dec_q;
    push_d      = 1'b0;
    push_char_d = push_char_q;
`ifdef PS2_SHIFT_EN
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
`endif
    lookup      = ps2_set2_to_ascii(rx_byte, shift_held);
    if (rx_vld) begin
      case (dec_q)
        BASE: begin
          if (rx_byte == PS2_EXT) begin
            dec_d = EXT;
          end else if (rx_byte == PS2_BRK) begin
            dec_d = BREAK;
          end else begin
`ifdef PS2_SHIFT_EN
            if (rx_byte == PS2_LSHIFT) lshift_d = 1'b1;
            if (rx_byte == PS2_RSHIFT) rshift_d = 1'b1;
`endif
            // Shift codes look up as zero, so they are never queued.
            if (lookup != 8'h00) begin
              push_d      = 1'b1;
              push_char_d = lookup;
            end
          end
        end
        EXT:       dec_d = (rx_byte == PS2_BRK) ? EXT_BREAK : BASE;
        BREAK: begin
`ifdef PS2_SHIFT_EN
          if (rx_byte == PS2_LSHIFT) lshift_d = 1'b0;
          if (rx_byte == PS2_RSHIFT) rshift_d = 1'b0;
`endif
          dec_d = BASE;
        end
        EXT_BREAK: dec_d = BASE;
        default:   dec_d = BASE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dec_q       <= BASE;
      push_q      <= 1'b0;
      push_char_q <= 8'h00;
`ifdef PS2_SHIFT_EN
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
`endif
    end else begin
      dec_q       <= dec_d;
      push_q      <= push_d;
      push_char_q <= push_char_d;
`ifdef PS2_SHIFT_EN
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
`endif
    end
  end

  // ---------------- character FIFO ----------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          overflow;
  logic [1:0]    err_q;

  assign KEY_VALID = (count_q != '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign do_pop    = KEY_VALID && KEY_READY;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push   = push_q && (!full || do_pop);
  assign overflow  = push_q && full && !do_pop;

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_char_q;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 2'b00;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_q + CW'(do_push) - CW'(do_pop);
      err_q[0] <= frame_err || (err_q[0] && !CLR_ERR);
      err_q[1] <= overflow  || (err_q[1] && !CLR_ERR);
    end
  end

  assign KEY_ASCII  = KEY_VALID ? mem_q[rd_ptr_q] : 8'h00;
  assign FIFO_COUNT = count_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
module tb_ps2_kbd_ctrl;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 300;
  localparam int HALF  = 20;
`ifdef PS2_SHIFT_EN
  localparam bit SHIFT_BUILD = 1'b1;
`else
  localparam bit SHIFT_BUILD = 1'b0;
`endif

  localparam logic [7:0] LETTER_CODES [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGIT_CODES [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] POOL [20] = '{
    8'h1C, 8'h32, 8'h16, 8'h45, 8'h4A, 8'h29, 8'h5A, 8'h66, 8'h41, 8'h49,
    8'hF0, 8'hE0, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h75, 8'h12, 8'h59, 8'h3E};

  logic       CLK = 1'b0;
  logic       RST;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] KEY_ASCII;
  logic       KEY_VALID;
  logic       KEY_READY;
  logic [3:0] FIFO_COUNT;
  logic [1:0] ERR;
  logic       CLR_ERR;
  logic       BUSY;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  bit         m_e0, m_f0, m_ls, m_rs;
  logic [1:0] m_err;
  string      shifted_digits = ")!@#$%^&*(";

  ps2_kbd_ctrl #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES   (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .KEY_ASCII (KEY_ASCII),
    .KEY_VALID (KEY_VALID),
    .KEY_READY (KEY_READY),
    .FIFO_COUNT(FIFO_COUNT),
    .ERR       (ERR),
    .CLR_ERR   (CLR_ERR),
    .BUSY      (BUSY)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_ascii(input logic [7:0] code, input bit sh);
    bit caps;
    bit syms;
    caps = sh || !SHIFT_BUILD;
    syms = sh;
    for (int i = 0; i < 26; i++)
      if (code == LETTER_CODES[i]) return (caps ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (code == DIGIT_CODES[i]) return syms ? 8'(shifted_digits[i]) : 8'h30 + 8'(i);
    case (code)
      8'h29: return 8'h20;
      8'h41: return 8'h2C;
      8'h49: return 8'h2E;
      8'h4A: return syms ? 8'h3F : 8'h2F;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      default: return 8'h00;
    endcase
  endfunction

  // Feed one correctly framed byte through the decode rules.
  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] c;
    if (m_f0) begin
      if (!m_e0 && SHIFT_BUILD) begin
        if (b == 8'h12) m_ls = 0;
        if (b == 8'h59) m_rs = 0;
      end
      m_e0 = 0;
      m_f0 = 0;
    end else if (m_e0) begin
      if (b == 8'hF0) m_f0 = 1;
      else            m_e0 = 0;
    end else if (b == 8'hE0) begin
      m_e0 = 1;
    end else if (b == 8'hF0) begin
      m_f0 = 1;
    end else if (SHIFT_BUILD && (b == 8'h12 || b == 8'h59)) begin
      if (b == 8'h12) m_ls = 1;
      else            m_rs = 1;
    end else begin
      c = ref_ascii(b, m_ls || m_rs);
      if (c != 8'h00) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(c);
        else                      m_err[1] = 1'b1;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic ps2_bit(input logic v);
    @(negedge CLK);
    PS2_DAT = v;
    repeat (HALF / 2) @(negedge CLK);
    PS2_CLK = 1'b0;
    repeat (HALF) @(negedge CLK);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(stop);
    repeat (10) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
    model_byte(b);
  endtask

  // Good frame whose stop bit is driven here; KEY_READY pulses for one
  // cycle starting pop_k cycles after the stop-bit falling edge.
  task automatic send_frame_pop(input logic [7:0] b, input int pop_k);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b);
    @(negedge CLK);
    PS2_DAT = 1'b1;
    repeat (HALF / 2) @(negedge CLK);
    PS2_CLK = 1'b0;
    for (int k = 1; k <= HALF; k++) begin
      @(negedge CLK);
      KEY_READY = (k == pop_k);
    end
    KEY_READY = 1'b0;
    PS2_CLK = 1'b1;
    repeat (10) @(negedge CLK);
  endtask

  task automatic clear_err();
    @(negedge CLK);
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    m_err = 2'b00;
  endtask

  // Scoreboard: pops every held character and compares in order.
  task automatic drain(input string tag);
    int guard;
    guard = 0;
    @(negedge CLK);
    KEY_READY = 1'b1;
    while (KEY_VALID && guard < 64) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s_extra: got char %h want none", tag, KEY_ASCII);
      end else begin
        if (KEY_ASCII !== exp_q[0]) begin
          n_fail++;
          $display("FAIL %s_char: got %h want %h", tag, KEY_ASCII, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      @(negedge CLK);
      guard++;
    end
    KEY_READY = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0 || guard >= 64) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d chars left in model (guard %0d) want 0", tag, exp_q.size(), guard);
      exp_q.delete();
    end
    n_cmp++;
    if (KEY_ASCII !== 8'h00 || KEY_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_empty: got valid %b ascii %h want 0 00", tag, KEY_VALID, KEY_ASCII);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1; PS2_CLK = 1'b1; PS2_DAT = 1'b1; KEY_READY = 1'b0; CLR_ERR = 1'b0;
    m_e0 = 0; m_f0 = 0; m_ls = 0; m_rs = 0; m_err = 2'b00;
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    // partial frame, then reset mid-frame
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    n_cmp++;
    if (BUSY !== 1'b1) begin n_fail++; $display("FAIL mid_frame_busy: got %b want 1", BUSY); end
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (KEY_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", KEY_VALID); end
    n_cmp++;
    if (KEY_ASCII !== 8'h00) begin n_fail++; $display("FAIL reset_ascii: got %h want 00", KEY_ASCII); end
    n_cmp++;
    if (FIFO_COUNT !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", FIFO_COUNT); end
    n_cmp++;
    if (ERR !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", ERR); end
  endtask

  task automatic test_latency();
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(LETTER_CODES[0][i]);
    ps2_bit(~^LETTER_CODES[0]);
    @(negedge CLK);
    PS2_DAT = 1'b1;
    repeat (HALF / 2) @(negedge CLK);
    PS2_CLK = 1'b0;
    repeat (4) @(negedge CLK);
    n_cmp++;
    if (KEY_VALID !== 1'b0) begin n_fail++; $display("FAIL latency_early: got valid %b want 0", KEY_VALID); end
    @(negedge CLK);
    n_cmp++;
    if (KEY_VALID !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b want 1", KEY_VALID); end
    n_cmp++;
    if (KEY_ASCII !== 8'h41) begin n_fail++; $display("FAIL latency_ascii: got %h want 41", KEY_ASCII); end
    n_cmp++;
    if (FIFO_COUNT !== 4'd1) begin n_fail++; $display("FAIL latency_count: got %0d want 1", FIFO_COUNT); end
    n_cmp++;
    if (ERR !== 2'b00) begin n_fail++; $display("FAIL latency_err: got %b want 00", ERR); end
    repeat (HALF - 5) @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (10) @(negedge CLK);
    model_byte(LETTER_CODES[0]);
    drain("latency");
  endtask

  task automatic test_break_ext();
    logic [7:0] seq [8];
    seq = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    n_cmp++;
    if (FIFO_COUNT !== 4'(exp_q.size())) begin
      n_fail++; $display("FAIL break_count: got %0d want %0d", FIFO_COUNT, exp_q.size());
    end
    n_cmp++;
    if (KEY_ASCII !== 8'h41) begin n_fail++; $display("FAIL break_head: got %h want 41", KEY_ASCII); end
    drain("break");
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int batch = 0; batch < 4; batch++) begin
      for (int n = 0; n < 6; n++) begin
        if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
        else                           b = POOL[$urandom_range(0, 19)];
        if ($urandom_range(0, 7) == 0) begin
          send_frame(b, 1'b1, 1'b1);
          m_err[0] = 1'b1;
        end else begin
          send_byte(b);
        end
      end
      send_byte(8'hAA);
      n_cmp++;
      if (FIFO_COUNT !== 4'(exp_q.size())) begin
        n_fail++; $display("FAIL random_count: got %0d want %0d", FIFO_COUNT, exp_q.size());
      end
      n_cmp++;
      if (ERR !== m_err) begin n_fail++; $display("FAIL random_err: got %b want %b", ERR, m_err); end
      drain("random");
      clear_err();
    end
  endtask

  task automatic test_frame_errors();
    send_frame(8'h16, 1'b1, 1'b1);
    n_cmp++;
    if (FIFO_COUNT !== 4'd0) begin n_fail++; $display("FAIL parity_count: got %0d want 0", FIFO_COUNT); end
    n_cmp++;
    if (ERR !== 2'b01) begin n_fail++; $display("FAIL parity_err: got %b want 01", ERR); end
    clear_err();
    n_cmp++;
    if (ERR !== 2'b00) begin n_fail++; $display("FAIL clr_err: got %b want 00", ERR); end
    send_frame(8'h16, 1'b0, 1'b0);
    n_cmp++;
    if (ERR !== 2'b01 || FIFO_COUNT !== 4'd0) begin
      n_fail++; $display("FAIL stop_err: got err %b count %0d want 01 0", ERR, FIFO_COUNT);
    end
    clear_err();
    ps2_bit(1'b1);
    repeat (5) @(negedge CLK);
    n_cmp++;
    if (ERR !== 2'b01 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL start_err: got err %b busy %b want 01 0", ERR, BUSY);
    end
    clear_err();
  endtask

  task automatic test_timeout();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    n_cmp++;
    if (BUSY !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_before: got %b want 1", BUSY); end
    repeat (TMO + HALF) @(negedge CLK);
    n_cmp++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_after: got %b want 0", BUSY); end
    n_cmp++;
    if (ERR[0] !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", ERR[0]); end
    clear_err();
    send_byte(8'h29);
    n_cmp++;
    if (KEY_ASCII !== 8'h20 || FIFO_COUNT !== 4'd1) begin
      n_fail++; $display("FAIL timeout_recover: got %h count %0d want 20 1", KEY_ASCII, FIFO_COUNT);
    end
    drain("timeout");
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    for (int i = 0; i < DEPTH + 1; i++) send_byte(LETTER_CODES[$urandom_range(0, 25)]);
    n_cmp++;
    if (FIFO_COUNT !== 4'(exp_q.size())) begin
      n_fail++; $display("FAIL ovf_count: got %0d want %0d", FIFO_COUNT, exp_q.size());
    end
    n_cmp++;
    if (ERR !== m_err) begin n_fail++; $display("FAIL ovf_err: got %b want %b", ERR, m_err); end
    n_cmp++;
    if (KEY_ASCII !== exp_q[0]) begin n_fail++; $display("FAIL ovf_head: got %h want %h", KEY_ASCII, exp_q[0]); end
    // full FIFO, pop lands in the same cycle as the push
    clear_err();
    b = LETTER_CODES[$urandom_range(0, 25)];
    send_frame_pop(b, 4);
    void'(exp_q.pop_front());
    model_byte(b);
    n_cmp++;
    if (FIFO_COUNT !== 4'(DEPTH) || ERR !== 2'b00) begin
      n_fail++; $display("FAIL full_push_pop: got count %0d err %b want %0d 00", FIFO_COUNT, ERR, DEPTH);
    end
    drain("overflow");
  endtask

`ifdef PS2_SHIFT_EN
  task automatic test_shift();
    logic [7:0] seq [5];
    seq = '{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    for (int i = 0; i < 5; i++) send_byte(seq[i]);
    n_cmp++;
    if (FIFO_COUNT !== 4'd2 || KEY_ASCII !== 8'h41) begin
      n_fail++; $display("FAIL shift_head: got count %0d head %h want 2 41", FIFO_COUNT, KEY_ASCII);
    end
    drain("shift");
  endtask
`endif

  // ---------------- main sequence / report ----------------
  initial begin
    test_reset();
    test_latency();
    test_break_ext();
    test_frame_errors();
    test_timeout();
    test_random();
    test_overflow();
`ifdef PS2_SHIFT_EN
    test_shift();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Receives PS/2 keyboard frames in the system clock domain and sequences them through a scan-code set-2 decoder. Make codes become ASCII; break codes and E0-extended codes are discarded. Characters are queued in a small FIFO and handed to the CPU I/O port over a valid/ready handshake. Sticky error flags report bad frames and lost characters.

Parameters:
FIFO_DEPTH, 8, character FIFO entries; power of 2, minimum 2.
TIMEOUT_CYCLES, 100000, idle CLK cycles between PS2_CLK falling edges before a partial frame is aborted (2 ms at 50 MHz).
SYNC_STAGES, 2, synchronizer flops on PS2_CLK and PS2_DAT; minimum 2.

Ports:
CLK  in  1  system clock.
RST  in  1  asynchronous, active-high reset.
PS2_CLK  in  1  keyboard clock, asynchronous to CLK.
PS2_DAT  in  1  keyboard data, asynchronous to CLK.
KEY_ASCII  out  8  FIFO head character; 0x00 when empty.
KEY_VALID  out  1  FIFO not empty.
KEY_READY  in  1  consumer accepts head when KEY_VALID=1.
FIFO_COUNT  out  $clog2(FIFO_DEPTH+1)  entries held.
ERR  out  2  sticky flags: [0] frame error (start, parity, stop or timeout), [1] FIFO overflow.
CLR_ERR  in  1  clears ERR.
BUSY  out  1  frame FSM not IDLE.

Behaviour:
- Reset: sync flops reset to 1; frame FSM IDLE; decode FSM BASE; FIFO emptied; KEY_VALID=0, KEY_ASCII=0x00, FIFO_COUNT=0, ERR=0, BUSY=0. Reset mid-frame discards partial data.
- Edge detect: fall = synced PS2_CLK previous 1, current 0. Data is sampled only on fall.
- Frame FSM:
  - IDLE: fall with DAT=0 -> DATA, bit counter cleared. Fall with DAT=1 -> stay IDLE and set ERR[0].
  - DATA: shift in 8 bits, LSB first; after bit 7 -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: odd parity over data plus parity bit correct and stop=1 -> byte pulse rx_vld for one cycle, then IDLE. Otherwise set ERR[0], drop the byte, go IDLE.
- Timeout: counter clears on every fall and holds 0 in IDLE. Reaching TIMEOUT_CYCLES-1 outside IDLE -> IDLE and set ERR[0].
- Decode FSM, advancing on rx_vld:
  - BASE: E0 -> EXT; F0 -> BREAK. Any other byte is looked up; a nonzero result is pushed, zero is ignored. AA, FA, EE, 00 and FF all map to zero.
  - EXT: F0 -> EXT_BREAK; other bytes -> BASE, no push.
  - BREAK: any byte -> BASE, no push.
  - EXT_BREAK: any byte -> BASE, no push.
- Map (set 2):
  - Letters 1C..1A as standard, giving 'A'-'Z' uppercase.
  - Digits: 45='0', 16='1', 1E='2', 26='3', 25='4', 2E='5', 36='6', 3D='7', 3E='8', 46='9'.
  - 29=' ', 41=',', 49='.', 4A='/', 5A=0x0D, 66=0x08.
  - Each code has exactly one entry.
- Latency: stop-bit fall detected at cycle T -> rx_vld at T+1 -> push at T+2 -> KEY_VALID=1 at T+3.
- FIFO:
  - Show-ahead: KEY_ASCII is the head, combinational from the storage array.
  - Pop when KEY_VALID && KEY_READY.
  - Push while full with no pop: the character is dropped and ERR[1] is set.
  - Push while full with a simultaneous pop: both succeed, count unchanged.
  - Push and pop together otherwise: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - KEY_READY while empty: no effect.
- ERR: CLR_ERR clears both bits. A new error in the same cycle as CLR_ERR wins, so that bit reads 1.

Optional Feature:
PS2_SHIFT_EN.
- Defined: tracks left shift (12) and right shift (59) make/break codes. With neither shift held, letters output lowercase ('a'-'z'); with either held, uppercase. Shifted digit row gives !@#$%^&*(); shifted 4A gives '?'. Shift codes are never pushed. State clears on reset.
- Undefined: always uppercase with unshifted symbols; 12 and 59 map to zero.

Decomposition:
- Package ps2_pkg:
  - decode state enum (BASE, EXT, BREAK, EXT_BREAK);
  - frame state enum (IDLE, DATA, PARITY, STOP);
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_LSHIFT=8'h12, PS2_RSHIFT=8'h59;
  - function ps2_set2_to_ascii(code, shift).
- Sub-module ps2_rx_frame: synchronizer, edge detect, frame FSM, timeout. Outputs rx_byte, rx_vld, frame_err, busy.
- The decode FSM and FIFO live in the top module.

Test Plan:
- Frame 1C (parity 0, stop 1), KEY_READY=0 -> KEY_VALID=1, KEY_ASCII=0x41 three cycles after the stop edge; FIFO_COUNT=1; ERR=00.
- Sequence 1C, F0, 1C -> exactly one entry 0x41 (break discarded). Then E0 75, E0 F0 75 -> no entries added.
- Frame 16 with wrong parity bit -> nothing pushed, ERR=01. Pulse CLR_ERR -> ERR=00.
- Start bit plus 4 data bits, then silence TIMEOUT_CYCLES -> BUSY returns 0, ERR[0]=1. Next valid frame 29 -> 0x20 pushed.
- Push 9 chars with FIFO_DEPTH=8, KEY_READY=0 -> FIFO_COUNT=8, ERR[1]=1, head is the first char. Hold KEY_READY=1 -> 8 chars pop in order, then KEY_VALID=0, KEY_ASCII=0x00.
- PS2_SHIFT_EN defined: 12, 1C, F0 12, 1C -> outputs 0x41 then 0x61.
